// File: rtl/cache_tag_ctrl_pkg.sv
// rtl/cache_tag_ctrl_pkg.sv - shared types and default geometry for the cache tag controller
// Purpose: FSM state encoding and default parameter values used by the
// interface, the tag array and the controller top.
// Ports: none (package).
package cache_tag_ctrl_pkg;

  localparam int N_WAYS_DEF     = 4;
  localparam int LINE_OFF_W_DEF = 6;
  localparam int TAG_W_DEF      = 18;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOOKUP = 2'd1,
    ST_REFILL = 2'd2,
    ST_COMMIT = 2'd3
  } tag_state_e;

endpackage

// File: rtl/cache_tag_ctrl_if.sv
// rtl/cache_tag_ctrl_if.sv - request/response, policy and refill bundle of the tag controller
// Purpose: groups every non-clock signal of cache_tag_ctrl.
// Ports: req_valid/req_addr/req_ready, invalidate, rp_write_en/rp_way_hit/
// rp_line_addr, way_select/way_select_bin, refill_req/refill_addr/refill_way/
// refill_done, resp_valid/resp_hit/resp_way.
// slave = controller side, master = requester/policy/back-end side.
interface cache_tag_ctrl_if
  import cache_tag_ctrl_pkg::*;
#(
  parameter int N_WAYS     = N_WAYS_DEF,
  parameter int LINE_OFF_W = LINE_OFF_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int NWAY_W     = $clog2(N_WAYS)
);
  logic                        req_valid;
  logic [TAG_W+LINE_OFF_W-1:0] req_addr;
  logic                        req_ready;
  logic                        invalidate;
  logic                        rp_write_en;
  logic [N_WAYS-1:0]           rp_way_hit;
  logic [LINE_OFF_W-1:0]       rp_line_addr;
  logic [N_WAYS-1:0]           way_select;
  logic [NWAY_W-1:0]           way_select_bin;
  logic                        refill_req;
  logic [TAG_W+LINE_OFF_W-1:0] refill_addr;
  logic [NWAY_W-1:0]           refill_way;
  logic                        refill_done;
  logic                        resp_valid;
  logic                        resp_hit;
  logic [NWAY_W-1:0]           resp_way;

  modport slave (
    input  req_valid, req_addr, invalidate, way_select, way_select_bin, refill_done,
    output req_ready, rp_write_en, rp_way_hit, rp_line_addr,
           refill_req, refill_addr, refill_way, resp_valid, resp_hit, resp_way
  );

  modport master (
    output req_valid, req_addr, invalidate, way_select, way_select_bin, refill_done,
    input  req_ready, rp_write_en, rp_way_hit, rp_line_addr,
           refill_req, refill_addr, refill_way, resp_valid, resp_hit, resp_way
  );
endinterface

// File: rtl/cache_tag_ctrl_tag_array.sv
// rtl/cache_tag_ctrl_tag_array.sv - flop-based tag/valid storage for all ways
// Purpose: synchronous single-way write, asynchronous read of every way at
// one set index, single-cycle flash-clear of all valid bits.
// Ports: clk, reset, clear_i, we_i, wr_way_i, wr_idx_i, wr_tag_i, rd_idx_i,
// rd_tag_o (all ways), rd_valid_o (all ways).
module cache_tag_array #(
  parameter int N_WAYS     = 4,
  parameter int LINE_OFF_W = 6,
  parameter int TAG_W      = 18,
  parameter int NWAY_W     = $clog2(N_WAYS)
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          clear_i,
  input  logic                          we_i,
  input  logic [NWAY_W-1:0]             wr_way_i,
  input  logic [LINE_OFF_W-1:0]         wr_idx_i,
  input  logic [TAG_W-1:0]              wr_tag_i,
  input  logic [LINE_OFF_W-1:0]         rd_idx_i,
  output logic [N_WAYS-1:0][TAG_W-1:0]  rd_tag_o,
  output logic [N_WAYS-1:0]             rd_valid_o
);
  localparam int N_SETS = 2 ** LINE_OFF_W;

  logic [TAG_W-1:0]  tag_q   [N_WAYS][N_SETS];
  logic [N_SETS-1:0] valid_q [N_WAYS];

  always_ff @(posedge clk) begin
    if (reset || clear_i) begin
      for (int w = 0; w < N_WAYS; w++) valid_q[w] <= '0;
    end else if (we_i) begin
      valid_q[wr_way_i][wr_idx_i] <= 1'b1;
    end
  end

  // Tag contents need no reset: a tag is only meaningful with its valid bit.
  always_ff @(posedge clk) begin
    if (we_i) tag_q[wr_way_i][wr_idx_i] <= wr_tag_i;
  end

  always_comb begin
    for (int w = 0; w < N_WAYS; w++) begin
      rd_tag_o[w]   = tag_q[w][rd_idx_i];
      rd_valid_o[w] = valid_q[w][rd_idx_i];
    end
  end
endmodule

// File: rtl/cache_tag_ctrl.sv
// rtl/cache_tag_ctrl.sv - tag lookup and miss-handling FSM in front of the replacement policy
// Purpose: resolves each request to a hit way or a miss, runs the refill
// handshake into the policy-chosen victim, installs the tag and strobes the
// policy update.
// Ports: clk, reset (sync, active-high), bus (cache_tag_ctrl_if.slave).
module cache_tag_ctrl
  import cache_tag_ctrl_pkg::*;
#(
  parameter int N_WAYS     = N_WAYS_DEF,
  parameter int LINE_OFF_W = LINE_OFF_W_DEF,
  parameter int TAG_W      = TAG_W_DEF,
  parameter int NWAY_W     = $clog2(N_WAYS)
) (
  input  logic             clk,
  input  logic             reset,
  cache_tag_ctrl_if.slave  bus
);
  localparam int ADDR_W = TAG_W + LINE_OFF_W;

  tag_state_e            state_q;
  logic [ADDR_W-1:0]     addr_q;
  logic [NWAY_W-1:0]     victim_q;
  logic                  refill_req_q;
  logic                  rp_write_en_q;
  logic [N_WAYS-1:0]     rp_way_hit_q;
  logic                  resp_valid_q;
  logic                  resp_hit_q;
  logic [NWAY_W-1:0]     resp_way_q;

  logic [LINE_OFF_W-1:0]          idx_q;
  logic [TAG_W-1:0]               req_tag;
  logic [N_WAYS-1:0][TAG_W-1:0]   rd_tag;
  logic [N_WAYS-1:0]              rd_valid;
  logic [N_WAYS-1:0]              hit_vec;
  logic [NWAY_W-1:0]              hit_bin;
  logic                           idle_free;
  logic                           inv_fire;
  logic                           accept;
  logic                           fill_we;

  assign idx_q   = addr_q[LINE_OFF_W-1:0];
  assign req_tag = addr_q[ADDR_W-1:LINE_OFF_W];

  // The hit response is registered and lands while the FSM already sits in
  // IDLE; blocking that cycle gives "ready again the cycle after the response".
  assign idle_free = (state_q == ST_IDLE) && !resp_valid_q;
  assign inv_fire  = !reset && idle_free && bus.invalidate;
  assign accept    = bus.req_valid && bus.req_ready;
  assign fill_we   = !reset && (state_q == ST_REFILL) && bus.refill_done;

  cache_tag_array #(
    .N_WAYS(N_WAYS), .LINE_OFF_W(LINE_OFF_W), .TAG_W(TAG_W), .NWAY_W(NWAY_W)
  ) u_tag_array (
    .clk       (clk),
    .reset     (reset),
    .clear_i   (inv_fire),
    .we_i      (fill_we),
    .wr_way_i  (victim_q),
    .wr_idx_i  (idx_q),
    .wr_tag_i  (req_tag),
    .rd_idx_i  (idx_q),
    .rd_tag_o  (rd_tag),
    .rd_valid_o(rd_valid)
  );

  always_comb begin
    hit_bin = '0;
    for (int w = 0; w < N_WAYS; w++) begin
      hit_vec[w] = rd_valid[w] && (rd_tag[w] == req_tag);
      // One-hot to binary: OR of the indices of set bits.
      if (hit_vec[w]) hit_bin = hit_bin | NWAY_W'(w);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      addr_q        <= '0;
      victim_q      <= '0;
      refill_req_q  <= 1'b0;
      rp_write_en_q <= 1'b0;
      rp_way_hit_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
    end else begin
      rp_write_en_q <= 1'b0;
      rp_way_hit_q  <= '0;
      resp_valid_q  <= 1'b0;
      resp_hit_q    <= 1'b0;
      resp_way_q    <= '0;
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            addr_q  <= bus.req_addr;
            state_q <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (|hit_vec) begin
            rp_write_en_q <= 1'b1;
            rp_way_hit_q  <= hit_vec;
            resp_valid_q  <= 1'b1;
            resp_hit_q    <= 1'b1;
            resp_way_q    <= hit_bin;
            state_q       <= ST_IDLE;
          end else begin
            victim_q     <= bus.way_select_bin;
            refill_req_q <= 1'b1;
            state_q      <= ST_REFILL;
          end
        end
        ST_REFILL: begin
          if (bus.refill_done) begin
            refill_req_q  <= 1'b0;
            rp_write_en_q <= 1'b1;
            rp_way_hit_q  <= N_WAYS'(1) << victim_q;
            resp_valid_q  <= 1'b1;
            resp_way_q    <= victim_q;
            state_q       <= ST_COMMIT;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && state_q == ST_LOOKUP) begin
      assert ($onehot0(hit_vec));
      if (hit_vec == '0) assert (bus.way_select == (N_WAYS'(1) << bus.way_select_bin));
    end
  end

  assign bus.req_ready    = !reset && idle_free && !bus.invalidate;
  assign bus.rp_write_en  = rp_write_en_q;
  assign bus.rp_way_hit   = rp_way_hit_q;
  assign bus.rp_line_addr = idx_q;
  assign bus.refill_req   = refill_req_q;
  assign bus.refill_addr  = addr_q;
  assign bus.refill_way   = victim_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_hit     = resp_hit_q;
  assign bus.resp_way     = resp_way_q;
endmodule
